// File: rtl/scroll_scheduler.sv
// Game-flow controller: IDLE/PLAY/OVER state machine that paces the scroll strobe and
// column counter for the pipe generator, keeps score and speeds up play as levels rise.
module scroll_scheduler #(
   parameter int BASE_PERIOD = 24,
   parameter int STEP        = 4,
   parameter int MIN_PERIOD  = 8,
   parameter int LEVEL_PTS   = 4,
   parameter int MAX_LEVEL   = 7,
   parameter int COUNT_MAX   = 17,
   parameter int SCORE_COL0  = 3,
   parameter int SCORE_COL1  = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       collide,
   output logic       tick,
   output logic [4:0] count,
   output logic [7:0] score,
   output logic [2:0] level,
   output logic       playing,
   output logic       game_over
);
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_OVER = 2'd2} state_t;

   state_t     state_q;
   logic       start_q;
   logic       tick_q;
   logic       playing_q;
   logic       game_over_q;
   logic [7:0] divider_q;
   logic [7:0] period_q;
   logic [7:0] score_q;
   logic [4:0] count_q;
   logic [2:0] level_q;

   logic       start_p;
   logic       reload;
   logic       score_hit;
   logic       level_up;
   logic [4:0] count_d;
   logic [7:0] score_d;
   logic [7:0] period_d;

   // Scroll period for a level; the subtraction is widened so underflow clamps to the floor.
   function automatic logic [7:0] scroll_period(input logic [2:0] lvl);
      logic [9:0] cut;
      cut = 10'(lvl) * 10'(STEP);
      if ((cut + 10'(MIN_PERIOD)) > 10'(BASE_PERIOD)) begin
         return 8'(MIN_PERIOD);
      end else begin
         return 8'(10'(BASE_PERIOD) - cut);
      end
   endfunction

   always_comb begin
      start_p   = start & ~start_q;
      reload    = (divider_q == (period_q - 8'd1));
      count_d   = (count_q == 5'(COUNT_MAX)) ? 5'd0 : (count_q + 5'd1);
      score_hit = tick_q & ((count_q == 5'(SCORE_COL0)) | (count_q == 5'(SCORE_COL1)));
      score_d   = (score_q == 8'hFF) ? score_q : (score_q + 8'd1);
      level_up  = (score_q != 8'hFF) & ((score_d % 8'(LEVEL_PTS)) == 8'd0)
                  & (level_q != 3'(MAX_LEVEL));
      period_d  = scroll_period(level_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         start_q     <= 1'b0;
         tick_q      <= 1'b0;
         playing_q   <= 1'b0;
         game_over_q <= 1'b0;
         divider_q   <= 8'd0;
         period_q    <= 8'(BASE_PERIOD);
         score_q     <= 8'd0;
         count_q     <= 5'd0;
         level_q     <= 3'd0;
      end else begin
         start_q <= start;
         case (state_q)
            ST_IDLE: begin
               tick_q <= 1'b0;
               if (start_p) begin
                  state_q     <= ST_PLAY;
                  playing_q   <= 1'b1;
                  game_over_q <= 1'b0;
                  divider_q   <= 8'd0;
                  period_q    <= 8'(BASE_PERIOD);
                  count_q     <= 5'd0;
                  score_q     <= 8'd0;
                  level_q     <= 3'd0;
               end
            end
            ST_PLAY: begin
               // A hit freezes everything, even a tick or score landing on the same edge.
               if (collide) begin
                  state_q     <= ST_OVER;
                  playing_q   <= 1'b0;
                  game_over_q <= 1'b1;
                  tick_q      <= 1'b0;
               end else begin
                  if (reload) begin
                     divider_q <= 8'd0;
                     tick_q    <= 1'b1;
                     period_q  <= period_d;
                  end else begin
                     divider_q <= divider_q + 8'd1;
                     tick_q    <= 1'b0;
                  end
                  if (tick_q) begin
                     count_q <= count_d;
                     if (score_hit) begin
                        score_q <= score_d;
                        if (level_up) begin
                           level_q <= level_q + 3'd1;
                        end
                     end
                  end
               end
            end
            ST_OVER: begin
               tick_q <= 1'b0;
               if (start_p) begin
                  state_q     <= ST_IDLE;
                  playing_q   <= 1'b0;
                  game_over_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               tick_q      <= 1'b0;
               playing_q   <= 1'b0;
               game_over_q <= 1'b0;
            end
         endcase
      end
   end

   assign tick      = tick_q;
   assign count     = count_q;
   assign score     = score_q;
   assign level     = level_q;
   assign playing   = playing_q;
   assign game_over = game_over_q;
endmodule

// File: tb/tb_scroll_scheduler.sv
// Scoreboard bench for scroll_scheduler: an event-level game model predicts every tick
// (cycle, count, score, level) and status snapshots; a negedge monitor compares them.
module tb_scroll_scheduler;
   localparam int BASE = 24;
   localparam int STEP = 4;
   localparam int MINP = 8;

   logic       clk = 1'b0;
   logic       reset, start, collide;
   logic       tick, playing, game_over;
   logic [4:0] count;
   logic [7:0] score;
   logic [2:0] level;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   typedef struct {int t; int cnt; int sc; int lv;} tick_rec_t;
   typedef struct {int t; bit pl; bit go; int cnt; int sc; int lv;} stat_rec_t;
   tick_rec_t exp_ticks[$];
   stat_rec_t exp_stats[$];

   scroll_scheduler dut (
      .clk(clk), .reset(reset), .start(start), .collide(collide),
      .tick(tick), .count(count), .score(score), .level(level),
      .playing(playing), .game_over(game_over)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int ref_period(input int lv);
      int p;
      p = BASE - lv * STEP;
      return (p < MINP) ? MINP : p;
   endfunction

   // Event-level game model. mode 0: game ends at cycle c; mode 1: ends on the count-12
   // tick once score>=20; mode 2: ends 3 cycles after the tick that brings score to 3.
   task automatic predict(input int e0, input int mode, inout int c,
                          output int fc, output int fs, output int fl);
      int t, per, cnt, sc, lv;
      bit scored;
      t = e0; per = BASE; cnt = 0; sc = 0; lv = 0;
      forever begin
         t = t + per;
         if (mode == 0 && t > c) break;
         exp_ticks.push_back('{t, cnt, sc, lv});
         if (mode == 1 && sc >= 20 && cnt == 12) begin c = t; break; end
         if (mode == 0 && t == c) break;
         per = ref_period(lv);
         scored = (cnt == 3 || cnt == 12) && sc < 255;
         if (scored) begin
            sc = sc + 1;
            if (sc % 4 == 0 && lv < 7) lv = lv + 1;
         end
         cnt = (cnt == 17) ? 0 : cnt + 1;
         if (mode == 2 && scored && sc == 3) begin c = t + 3; break; end
      end
      fc = cnt; fs = sc; fl = lv;
   endtask

   always @(negedge clk) begin
      tick_rec_t e;
      stat_rec_t s;
      if (tick === 1'b1) begin
         vectors++;
         if (exp_ticks.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_tick: at cycle %0d count=%0d score=%0d, required no tick",
                     cyc, count, score);
         end else begin
            e = exp_ticks.pop_front();
            if (e.t != cyc || count !== 5'(e.cnt) || score !== 8'(e.sc) || level !== 3'(e.lv)) begin
               miscompares++;
               $display("FAIL tick: got cycle=%0d count=%0d score=%0d level=%0d, required cycle=%0d count=%0d score=%0d level=%0d",
                        cyc, count, score, level, e.t, e.cnt, e.sc, e.lv);
            end
         end
      end else if (exp_ticks.size() > 0 && exp_ticks[0].t <= cyc) begin
         e = exp_ticks.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL missed_tick: no tick at cycle %0d, required tick with count=%0d", e.t, e.cnt);
      end
      while (exp_stats.size() > 0 && exp_stats[0].t <= cyc) begin
         s = exp_stats.pop_front();
         vectors++;
         if (playing !== s.pl || game_over !== s.go || tick !== 1'b0 || count !== 5'(s.cnt)
             || score !== 8'(s.sc) || level !== 3'(s.lv)) begin
            miscompares++;
            $display("FAIL status@%0d: got playing=%b over=%b tick=%b count=%0d score=%0d level=%0d, required playing=%b over=%b tick=0 count=%0d score=%0d level=%0d",
                     cyc, playing, game_over, tick, count, score, level, s.pl, s.go, s.cnt, s.sc, s.lv);
         end
      end
   end

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic play_game(input int mode, input int c_off, input bit end_reset);
      int e0, c, fc, fs, fl;
      @(negedge clk);
      start = 1'b1;
      e0 = cyc + 1;
      c = e0 + c_off;
      predict(e0, mode, c, fc, fs, fl);
      exp_stats.push_back('{e0, 1'b1, 1'b0, 0, 0, 0});
      repeat ($urandom_range(1, 10)) @(negedge clk);
      start = 1'b0;
      wait_until(c);
      if (end_reset) begin
         reset = 1'b1;
         exp_stats.push_back('{c + 1, 1'b0, 1'b0, 0, 0, 0});
         @(negedge clk);
         reset = 1'b0;
      end else begin
         collide = 1'b1;
         exp_stats.push_back('{c + 1, 1'b0, 1'b1, fc, fs, fl});
         @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            collide = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         collide = 1'b0;
         exp_stats.push_back('{cyc + 1, 1'b0, 1'b1, fc, fs, fl});
         @(negedge clk);
         start = 1'b1;
         exp_stats.push_back('{cyc + 1, 1'b0, 1'b0, fc, fs, fl});
         repeat (3) @(negedge clk);
         start = 1'b0;
         for (int i = 0; i < 6; i++) begin
            collide = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         collide = 1'b0;
         exp_stats.push_back('{cyc + 1, 1'b0, 1'b0, fc, fs, fl});
         @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; collide = 1'b0;
      exp_stats.push_back('{1, 1'b0, 1'b0, 0, 0, 0});
      exp_stats.push_back('{2, 1'b0, 1'b0, 0, 0, 0});
      wait_until(2);
      reset = 1'b0;
      play_game(1, 0, 1'b0);
      play_game(2, 0, 1'b1);
      for (int g = 0; g < 8; g++) begin
         play_game(0, $urandom_range(12, 1500), 1'($urandom_range(0, 1)));
      end
      repeat (5) @(negedge clk);
      vectors++;
      if (exp_ticks.size() != 0 || exp_stats.size() != 0) begin
         miscompares++;
         $display("FAIL leftover: %0d ticks and %0d status checks pending, required 0",
                  exp_ticks.size(), exp_stats.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1, "watchdog");
   end
endmodule
